// File: rtl/regfile_pkg.sv
// Shared register-file types, default sizes and the flat-bus port slicing helper.
// No state; purely combinational helpers.
package regfile_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int FIELD_BUS_W = 256;
  localparam int FIELD_MAX_W = 64;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  // Extracts field idx of width w from a flat port bus (fields up to 64 bits).
  function automatic logic [FIELD_MAX_W-1:0] port_field(
    input logic [FIELD_BUS_W-1:0] bus,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [FIELD_BUS_W-1:0] mask;
    mask = (FIELD_BUS_W'(1) << w) - FIELD_BUS_W'(1);
    return FIELD_MAX_W'((bus >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: issue sets, writeback clears, set wins on a same-cycle collision.
// Updates on the rising edge; always accepts (no backpressure).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  input  logic [NWR-1:0]      regwrite,
  input  logic [NWR*AW-1:0]   adr_wr_reg,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    wr_adr [NWR];

  for (genvar k = 0; k < NWR; k++) begin : g_wr_adr
    assign wr_adr[k] = AW'(port_field(FIELD_BUS_W'(adr_wr_reg), k, AW));
  end

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (regwrite[k] && wr_adr[k] != '0) busy_d[wr_adr[k]] = 1'b0;
    end
    // Applied after the clears: a newer producer owns the register.
    if (issue_en && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with r0 hardwired to zero and an integrated busy scoreboard.
// Zero-latency reads, writes on the rising edge; REGFILE_BYPASS_EN adds same-cycle write forwarding.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       regwrite,
  input  logic [NWR*AW-1:0]    adr_wr_reg,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NRD*AW-1:0]    adr_rd,
  output logic [NRD*XLEN-1:0]  reg_data,
  output logic [NRD-1:0]       reg_busy,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd,
  output logic [NREGS-1:0]     busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   wr_adr [NWR];
  logic [XLEN-1:0] wr_dat [NWR];
  logic [AW-1:0]   rd_adr [NRD];

  for (genvar k = 0; k < NWR; k++) begin : g_wr
    assign wr_adr[k] = AW'(port_field(FIELD_BUS_W'(adr_wr_reg), k, AW));
    assign wr_dat[k] = XLEN'(port_field(FIELD_BUS_W'(wr_data), k, XLEN));
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign rd_adr[j] = AW'(port_field(FIELD_BUS_W'(adr_rd), j, AW));
  end

  // Ascending port order lets port 1 override port 0 on an address collision.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++) begin
      if (regwrite[k] && wr_adr[k] != '0) regs_d[wr_adr[k]] = wr_dat[k];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .regwrite   (regwrite),
    .adr_wr_reg (adr_wr_reg),
    .busy_vec   (busy_vec)
  );

  always_comb begin
    reg_data = '0;
    reg_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      reg_data[j*XLEN +: XLEN] = regs_q[rd_adr[j]];
      reg_busy[j]              = busy_vec[rd_adr[j]];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is gated by reset so outputs read zero while reset is held.
      for (int k = 0; k < NWR; k++) begin
        if (rst && regwrite[k] && wr_adr[k] == rd_adr[j] && rd_adr[j] != '0) begin
          reg_data[j*XLEN +: XLEN] = wr_dat[k];
          reg_busy[j]              = issue_en && (issue_rd == rd_adr[j]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: directed vector table, bypass/reset sequences, then random traffic vs a reference model.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      regwrite;
  logic [NWR*AW-1:0]   adr_wr_reg;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   adr_rd;
  logic [NRD*XLEN-1:0] reg_data;
  logic [NRD-1:0]      reg_busy;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic [NREGS-1:0]    busy_vec;

  int n_vec = 0;
  int n_bad = 0;

  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_multiport #(
    .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NWR (NWR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regwrite   (regwrite),
    .adr_wr_reg (adr_wr_reg),
    .wr_data    (wr_data),
    .adr_rd     (adr_rd),
    .reg_data   (reg_data),
    .reg_busy   (reg_busy),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      we;
    reg_addr_t       wa0, wa1;
    reg_data_t       wd0, wd1;
    logic            ie;
    reg_addr_t       ir;
    reg_addr_t       ra0, ra1;
    reg_data_t       ed0, ed1;
    logic            eb0, eb1;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int j);
    int a;
    a = int'(adr_rd[j*AW +: AW]);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst) begin
      for (int k = NWR-1; k >= 0; k--)
        if (regwrite[k] && int'(adr_wr_reg[k*AW +: AW]) == a) return wr_data[k*XLEN +: XLEN];
    end
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int j);
    int a;
    a = int'(adr_rd[j*AW +: AW]);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rst) begin
      for (int k = 0; k < NWR; k++)
        if (regwrite[k] && int'(adr_wr_reg[k*AW +: AW]) == a) return issue_en && int'(issue_rd) == a;
    end
`endif
    return m_busy[a];
  endfunction

  // Applies the architectural effect of one rising edge to the model.
  task automatic model_edge();
    int a;
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
      m_busy = '0;
      return;
    end
    for (int k = 0; k < NWR; k++) begin
      a = int'(adr_wr_reg[k*AW +: AW]);
      if (regwrite[k] && a != 0) begin
        m_mem[a]  = wr_data[k*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < NRD; j++) begin
      check($sformatf("%s data%0d", tag, j), 64'(reg_data[j*XLEN +: XLEN]), 64'(exp_data(j)));
      check($sformatf("%s busy%0d", tag, j), 64'(reg_busy[j]), 64'(exp_busy(j)));
    end
    check($sformatf("%s busy_vec", tag), 64'(busy_vec), 64'(m_busy));
  endtask

  task automatic idle_inputs();
    regwrite = '0; adr_wr_reg = '0; wr_data = '0; issue_en = 1'b0; issue_rd = '0;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    m_busy = '0;
    rst = 1'b0;
    idle_inputs();
    adr_rd = {5'd2, 5'd1};

    tbl[0] = '{2'b01, 5'd1, 5'd0, 32'h3,        32'h0,  1'b0, 5'd0, 5'd1, 5'd2, 32'h3,  32'h0,  1'b0, 1'b0};
    tbl[1] = '{2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0,  1'b1, 5'd0, 5'd0, 5'd1, 32'h0,  32'h3,  1'b0, 1'b0};
    tbl[2] = '{2'b11, 5'd5, 5'd5, 32'h11,       32'h22, 1'b0, 5'd0, 5'd5, 5'd5, 32'h22, 32'h22, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b1, 5'd7, 5'd7, 5'd5, 32'h0,  32'h22, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 5'd7, 5'd0, 32'h77,       32'h0,  1'b0, 5'd0, 5'd7, 5'd5, 32'h77, 32'h22, 1'b0, 1'b0};
    tbl[5] = '{2'b01, 5'd7, 5'd0, 32'h78,       32'h0,  1'b1, 5'd7, 5'd7, 5'd5, 32'h78, 32'h22, 1'b1, 1'b0};
    tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b1, 5'd7, 5'd7, 5'd5, 32'h78, 32'h22, 1'b1, 1'b0};
    tbl[7] = '{2'b11, 5'd3, 5'd7, 32'h33,       32'h9,  1'b0, 5'd0, 5'd3, 5'd7, 32'h33, 32'h9,  1'b0, 1'b0};

    // Reset held: everything reads zero.
    #3;
    check("reset data", 64'(reg_data), 64'h0);
    check("reset busy", 64'(reg_busy), 64'h0);
    check("reset busy_vec", 64'(busy_vec), 64'h0);
    #7 rst = 1'b1;
    @(posedge clk); model_edge(); #1;
    @(negedge clk);
    check("post-reset data", 64'(reg_data), 64'h0);
    check("post-reset busy", 64'(busy_vec), 64'h0);

    foreach (tbl[i]) begin
      regwrite   = tbl[i].we;
      adr_wr_reg = {tbl[i].wa1, tbl[i].wa0};
      wr_data    = {tbl[i].wd1, tbl[i].wd0};
      issue_en   = tbl[i].ie;
      issue_rd   = tbl[i].ir;
      @(posedge clk); model_edge(); #1;
      idle_inputs();
      adr_rd = {tbl[i].ra1, tbl[i].ra0};
      @(negedge clk);
      check($sformatf("tbl%0d data0", i), 64'(reg_data[XLEN-1:0]),      64'(tbl[i].ed0));
      check($sformatf("tbl%0d data1", i), 64'(reg_data[2*XLEN-1:XLEN]), 64'(tbl[i].ed1));
      check($sformatf("tbl%0d busy0", i), 64'(reg_busy[0]), 64'(tbl[i].eb0));
      check($sformatf("tbl%0d busy1", i), 64'(reg_busy[1]), 64'(tbl[i].eb1));
    end
    check("tbl busy_vec0", 64'(busy_vec[0]), 64'h0);

    // Same-cycle write/read of register 4 (previously never written).
    regwrite = 2'b01; adr_wr_reg = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
    issue_en = 1'b1; issue_rd = 5'd2; adr_rd = {5'd7, 5'd4};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass same-cycle", 64'(reg_data[XLEN-1:0]), 64'h55);
`else
    check("no-bypass same-cycle", 64'(reg_data[XLEN-1:0]), 64'h0);
`endif
    @(posedge clk); model_edge(); #1;
    idle_inputs();
    @(negedge clk);
    check("write4 visible", 64'(reg_data[XLEN-1:0]), 64'h55);
    check("issue2 busy", 64'(busy_vec), 64'h4);

    // Asynchronous reset mid-cycle with a write pending.
    @(posedge clk); model_edge(); #2;
    regwrite = 2'b01; adr_wr_reg = {5'd0, 5'd4}; wr_data = {32'h0, 32'hAA};
    issue_en = 1'b1; issue_rd = 5'd9; adr_rd = {5'd5, 5'd4};
    rst = 1'b0;
    #1;
    check("midreset data", 64'(reg_data), 64'h0);
    check("midreset busy", 64'(reg_busy), 64'h0);
    check("midreset busy_vec", 64'(busy_vec), 64'h0);
    @(posedge clk); model_edge();
    @(negedge clk);
    check("held reset data", 64'(reg_data), 64'h0);
    idle_inputs();
    #1 rst = 1'b1;
    @(posedge clk); model_edge(); #1;
    @(negedge clk);
    check("write discarded", 64'(reg_data), 64'h0);
    check("busy discarded", 64'(busy_vec), 64'h0);

    // Random traffic against the model, addresses biased for collisions.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); model_edge(); #1;
      regwrite = NWR'($urandom_range(0, 3));
      for (int k = 0; k < NWR; k++) begin
        adr_wr_reg[k*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        wr_data[k*XLEN +: XLEN] = $urandom;
      end
      for (int j = 0; j < NRD; j++)
        adr_rd[j*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = AW'($urandom_range(0, 7));
      @(negedge clk);
      check_all($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
